// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug dump sequencer: FSM states, dump phases
// and the byte-count helper. The optional checksum byte is selected by DUMP_CHECKSUM_EN.
package dbg_pkg;

  localparam int NBITS_DEF      = 32;
  localparam int BYTES_PER_WORD = NBITS_DEF / 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LATCH,
    ST_SEND,
    ST_WAIT_TX,
    ST_NEXT,
    ST_CHK,
    ST_CHK_WAIT,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    PH_PC,
    PH_REG,
    PH_MEM
  } phase_t;

  // Bytes produced by one complete dump, including the optional checksum byte.
  function automatic int dump_bytes(input int nbits, input int bank_size,
                                    input int dm_words, input bit checksum);
    return (1 + bank_size + dm_words) * (nbits / 8) + (checksum ? 1 : 0);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one word and presents it MSB-first, one byte at a time, with a flag on the
// final byte of the word.
module word_serializer #(
  parameter int NBITS  = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [NBITS-1:0]  din,
  output logic [BYTE_W-1:0] top_byte,
  output logic              last_byte
);

  localparam int NB = NBITS / BYTE_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [NBITS-1:0] shift_q;
  logic [CW-1:0]    byte_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shift_q  <= din;
      byte_cnt <= '0;
    end else if (shift) begin
      shift_q  <= shift_q << BYTE_W;
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign top_byte  = shift_q[NBITS-1 -: BYTE_W];
  assign last_byte = (byte_cnt == CW'(NB - 1));

endmodule

// File: rtl/dump_sequencer.sv
// Debug dump controller: once started, walks PC, the register bank and a window of
// data memory, sending every word MSB-first to the UART. Define DUMP_CHECKSUM_EN to
// append an XOR checksum byte at the end of the dump.
module dump_sequencer
  import dbg_pkg::*;
#(
  parameter int NBITS          = 32,
  parameter int RBITS          = 5,
  parameter int BANK_SIZE      = 32,
  parameter int DM_ADDR_LENGTH = 32,
  parameter int DM_WORDS       = 16,
  parameter int BYTE_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NBITS-1:0]          current_pc,
  input  logic [NBITS-1:0]          rb_data,
  input  logic [NBITS-1:0]          dm_data,
  input  logic                      tx_done,
  output logic                      dbg_own,
  output logic [RBITS-1:0]          rb_addr,
  output logic [DM_ADDR_LENGTH-1:0] dm_addr,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_byte,
  output logic                      busy,
  output logic                      done
);

  localparam int IW = 16;

  state_t          state, next_state;
  phase_t          phase, next_phase;
  logic [IW-1:0]   index, next_index;
  logic            last_item;
  logic            load, shift_en, last_byte;
  logic [NBITS-1:0] word_in;
  logic [BYTE_W-1:0] word_byte;

  word_serializer #(.NBITS(NBITS), .BYTE_W(BYTE_W)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift_en),
    .din      (word_in),
    .top_byte (word_byte),
    .last_byte(last_byte)
  );

  always_comb begin
    case (phase)
      PH_REG:  word_in = rb_data;
      PH_MEM:  word_in = dm_data;
      default: word_in = current_pc;
    endcase
  end

  // Item successor: PC -> REG 0..BANK_SIZE-1 -> MEM 0..DM_WORDS-1.
  always_comb begin
    next_phase = phase;
    next_index = index;
    last_item  = 1'b0;
    case (phase)
      PH_PC: begin
        next_phase = PH_REG;
        next_index = '0;
      end
      PH_REG: begin
        if (index == IW'(BANK_SIZE - 1)) begin
          next_phase = PH_MEM;
          next_index = '0;
        end else begin
          next_index = index + 1'b1;
        end
      end
      default: begin
        if (index == IW'(DM_WORDS - 1)) last_item = 1'b1;
        else                            next_index = index + 1'b1;
      end
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    tx_start   = 1'b0;
    case (state)
      ST_IDLE:    if (start) next_state = ST_ADDR;
      ST_ADDR:    next_state = ST_LATCH;
      ST_LATCH: begin
        load       = 1'b1;
        next_state = ST_SEND;
      end
      ST_SEND: begin
        tx_start   = 1'b1;
        next_state = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          if (last_byte) begin
            next_state = ST_NEXT;
          end else begin
            shift_en   = 1'b1;
            next_state = ST_SEND;
          end
        end
      end
      ST_NEXT: begin
`ifdef DUMP_CHECKSUM_EN
        next_state = last_item ? ST_CHK : ST_ADDR;
`else
        next_state = last_item ? ST_FIN : ST_ADDR;
`endif
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CHK: begin
        tx_start   = 1'b1;
        next_state = ST_CHK_WAIT;
      end
      ST_CHK_WAIT: if (tx_done) next_state = ST_FIN;
`endif
      ST_FIN:     next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Addresses are set on entry to ADDR so read data is valid in LATCH, then held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= PH_PC;
      index   <= '0;
      rb_addr <= '0;
      dm_addr <= '0;
    end else if (state == ST_IDLE && start) begin
      phase   <= PH_PC;
      index   <= '0;
      rb_addr <= '0;
      dm_addr <= '0;
    end else if (state == ST_NEXT && !last_item) begin
      phase <= next_phase;
      index <= next_index;
      if (next_phase == PH_REG) rb_addr <= next_index[RBITS-1:0];
      if (next_phase == PH_MEM) dm_addr <= DM_ADDR_LENGTH'(next_index) << 2;
    end else if (state == ST_FIN) begin
      rb_addr <= '0;
      dm_addr <= '0;
    end
  end

  assign busy    = (state != ST_IDLE) && (state != ST_FIN);
  assign dbg_own = busy;
  assign done    = (state == ST_FIN);

`ifdef DUMP_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         csum <= '0;
    else if (state == ST_IDLE && start) csum <= '0;
    else if (state == ST_SEND)        csum <= csum ^ word_byte;
  end

  assign tx_byte = (state == ST_CHK || state == ST_CHK_WAIT) ? csum : word_byte;
`else
  assign tx_byte = word_byte;
`endif

endmodule

// File: tb/tb_dump_sequencer.sv
// Self-checking bench for dump_sequencer: directed and randomized dumps compared
// byte-by-byte against an expected stream built from the dump ordering rules.
module tb_dump_sequencer;

  localparam int NBITS     = 32;
  localparam int BANK_SIZE = 32;
  localparam int DM_WORDS  = 16;
  localparam int WORD_BYTES = (1 + BANK_SIZE + DM_WORDS) * NBITS / 8;
`ifdef DUMP_CHECKSUM_EN
  localparam int TOTAL_BYTES = WORD_BYTES + 1;
`else
  localparam int TOTAL_BYTES = WORD_BYTES;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] current_pc = '0;
  logic [31:0] rb_data = '0;
  logic [31:0] dm_data = '0;
  logic        tx_done = 1'b0;
  logic        dbg_own;
  logic [4:0]  rb_addr;
  logic [31:0] dm_addr;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        busy;
  logic        done;

  dump_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .current_pc(current_pc),
    .rb_data   (rb_data),
    .dm_data   (dm_data),
    .tx_done   (tx_done),
    .dbg_own   (dbg_own),
    .rb_addr   (rb_addr),
    .dm_addr   (dm_addr),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [BANK_SIZE];
  logic [31:0] mem  [DM_WORDS];

  // Register bank and data memory with one-cycle read latency.
  always @(posedge clk) begin
    rb_data <= regs[rb_addr];
    dm_data <= mem[dm_addr[5:2]];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // UART stand-in: optional tx_done glitch coincident with tx_start, then a real one.
  int delay_min = 3;
  int delay_max = 3;
  bit glitch_mode = 1'b0;

  always begin
    int d;
    @(negedge clk);
    if (tx_start === 1'b1) begin
      d = int'($urandom_range(delay_max, delay_min));
      if (glitch_mode && ($urandom_range(1, 0) == 1)) begin
        tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        repeat (d - 1) @(posedge clk);
      end else begin
        repeat (d) @(posedge clk);
      end
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  // Observed stream and protocol counters.
  logic [7:0]  cap_byte [$];
  logic [4:0]  cap_rb   [$];
  logic [31:0] cap_dm   [$];
  int  done_cnt = 0;
  int  wide_cnt = 0;
  int  own_err  = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      cap_byte.push_back(tx_byte);
      cap_rb.push_back(rb_addr);
      cap_dm.push_back(dm_addr);
      if (prev_start === 1'b1) wide_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (busy !== dbg_own) own_err++;
    prev_start = tx_start;
  end

  // Expected stream derived from the dump order and MSB-first byte rule.
  logic [7:0]  exp_byte [$];
  logic [4:0]  exp_rb   [$];
  logic [31:0] exp_dm   [$];

  task automatic push_word(input logic [31:0] w, input logic [4:0] ra, input logic [31:0] da);
    for (int b = 3; b >= 0; b--) begin
      exp_byte.push_back(8'((w >> (8 * b)) & 32'hFF));
      exp_rb.push_back(ra);
      exp_dm.push_back(da);
    end
  endtask

  task automatic build_expected();
    logic [7:0] x;
    exp_byte.delete();
    exp_rb.delete();
    exp_dm.delete();
    push_word(current_pc, 5'd0, 32'd0);
    for (int r = 0; r < BANK_SIZE; r++) push_word(regs[r], 5'(r), 32'd0);
    for (int w = 0; w < DM_WORDS; w++) push_word(mem[w], 5'(BANK_SIZE - 1), 32'(w * 4));
`ifdef DUMP_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_byte[i]) x = x ^ exp_byte[i];
    exp_byte.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  task automatic begin_dump();
    build_expected();
    cap_byte.delete();
    cap_rb.delete();
    cap_dm.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int cyc = 0;
    while (cap_byte.size() < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_bytes_timeout"}, 64'(cap_byte.size() >= n), 64'd1);
  endtask

  task automatic finish_dump(input string tag, input int done_before);
    int cyc = 0;
    while (done_cnt == done_before && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_timeout"}, 64'(cyc < 5000), 64'd1);
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt - done_before), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_own_after"}, 64'(dbg_own), 64'd0);
    check({tag, "_byte_count"}, 64'(cap_byte.size()), 64'(TOTAL_BYTES));
    for (int i = 0; i < cap_byte.size() && i < exp_byte.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 64'(cap_byte[i]), 64'(exp_byte[i]));
      if (i < WORD_BYTES) begin
        check($sformatf("%s_rb%0d", tag, i), 64'(cap_rb[i]), 64'(exp_rb[i]));
        check($sformatf("%s_dm%0d", tag, i), 64'(cap_dm[i]), 64'(exp_dm[i]));
      end
    end
  endtask

  initial begin
    int d0;
    foreach (regs[i]) regs[i] = '0;
    foreach (mem[i]) mem[i] = '0;

    // Reset held with start asserted: everything quiet.
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_own", 64'(dbg_own), 64'd0);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rb_addr", 64'(rb_addr), 64'd0);
    check("rst_dm_addr", 64'(dm_addr), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_tx_start_cnt", 64'(cap_byte.size()), 64'd0);

    // Directed full dump: known PC, register and memory patterns, tx_done 3 cycles out.
    current_pc = 32'h0040_0010;
    for (int i = 0; i < BANK_SIZE; i++) regs[i] = 32'(i) * 32'h0101_0101;
    for (int w = 0; w < DM_WORDS; w++) mem[w] = 32'hA500_0000 + 32'(w);
    d0 = done_cnt;
    begin_dump();
    wait_bytes(4, "pc");
    check("pc_b0", 64'(cap_byte[0]), 64'h00);
    check("pc_b1", 64'(cap_byte[1]), 64'h40);
    check("pc_b2", 64'(cap_byte[2]), 64'h00);
    check("pc_b3", 64'(cap_byte[3]), 64'h10);
    finish_dump("full", d0);

    // Busy guard: second start mid-dump plus tx_done glitches during SEND.
    glitch_mode = 1'b1;
    delay_min = 1;
    delay_max = 5;
    current_pc = $urandom;
    foreach (regs[i]) regs[i] = $urandom;
    foreach (mem[i]) mem[i] = $urandom;
    d0 = done_cnt;
    begin_dump();
    wait_bytes(20, "guard");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_dump("guard", d0);

    // Abort after byte 50, then a clean restart from PC byte 0.
    current_pc = $urandom;
    foreach (regs[i]) regs[i] = $urandom;
    foreach (mem[i]) mem[i] = $urandom;
    d0 = done_cnt;
    begin_dump();
    wait_bytes(50, "abort");
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_own", 64'(dbg_own), 64'd0);
    check("abort_tx_start", 64'(tx_start), 64'd0);
    repeat (10) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    begin_dump();
    finish_dump("restart", d0);

    // Fully randomized dump.
    current_pc = $urandom;
    foreach (regs[i]) regs[i] = $urandom;
    foreach (mem[i]) mem[i] = $urandom;
    d0 = done_cnt;
    begin_dump();
    finish_dump("rand", d0);

`ifdef DUMP_CHECKSUM_EN
    // All-zero data with PC=0xFF: checksum byte must be 0xFF.
    current_pc = 32'h0000_00FF;
    foreach (regs[i]) regs[i] = '0;
    foreach (mem[i]) mem[i] = '0;
    d0 = done_cnt;
    begin_dump();
    finish_dump("chk", d0);
    check("chk_last_byte", 64'(cap_byte[cap_byte.size() - 1]), 64'hFF);
`endif

    check("tx_start_single_cycle", 64'(wide_cnt), 64'd0);
    check("own_tracks_busy", 64'(own_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dump_sequencer.md
Name: dump_sequencer

Overview:
- Debug-side controller that takes ownership of the register bank read port and data memory address once the pipeline halts.
- Walks PC, every register, then a configurable window of data memory words, serializing each 32-bit word into bytes for the UART transmitter.
- Sits between the debug unit's command FSM (start pulse) and the UART tx; drives the datapath mux select that chooses debug vs pipeline addressing.

Parameters:
- NBITS, 32, width of PC/register/memory data words (multiple of 8)
- RBITS, 5, register bank address width
- BANK_SIZE, 32, number of registers dumped
- DM_ADDR_LENGTH, 32, data memory byte-address width
- DM_WORDS, 16, number of data memory words dumped starting at byte address 0
- BYTE_W, 8, UART byte width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a dump
- current_pc  in  NBITS  PC value to report
- rb_data  in  NBITS  register bank read data (1-cycle latency after rb_addr)
- dm_data  in  NBITS  data memory read data (1-cycle latency after dm_addr)
- tx_done  in  1  UART tx byte-complete tick
- dbg_own  out  1  1 = debug side drives RB/DM addresses
- rb_addr  out  RBITS  register read address
- dm_addr  out  DM_ADDR_LENGTH  data memory byte address
- tx_start  out  1  one-cycle pulse launching tx_byte
- tx_byte  out  BYTE_W  byte to transmit
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse when the last byte completes

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters and shift register cleared.
- States: IDLE, ADDR, LATCH, SEND, WAIT_TX, NEXT, (CHK, CHK_WAIT with macro), FIN.
- IDLE: start=1 -> ADDR, busy=1, dbg_own=1, phase=PC, index=0. start while busy is ignored.
- ADDR: drive address for the current item (rb_addr=index for REG, dm_addr=index*4 for MEM; PC needs none); 1 cycle wait for read latency.
- LATCH: load the word into the shift register (current_pc, rb_data or dm_data per phase); byte_cnt=0.
- SEND: tx_byte = shift[NBITS-1 -: 8] (MSB first); tx_start=1 for exactly this cycle -> WAIT_TX.
- WAIT_TX: hold tx_byte stable; wait indefinitely for tx_done. On tx_done: if byte_cnt==NBITS/8-1 -> NEXT, else shift left 8, byte_cnt++, -> SEND.
- NEXT ordering is PC (1 word) -> REG 0..BANK_SIZE-1 -> MEM 0..DM_WORDS-1.
  - REG index wraps to 0 on phase change.
  - After the last MEM word -> FIN (or CHK with macro).
- FIN: done=1 for one cycle, busy=0, dbg_own=0 -> IDLE.
- Total bytes = (1+BANK_SIZE+DM_WORDS)*NBITS/8; default 196.
- tx_done outside WAIT_TX is ignored. A tx_done in the same cycle as tx_start is not accepted.
- rb_addr and dm_addr hold their last value while in SEND/WAIT_TX; return to 0 in IDLE.
- Reset mid-dump aborts immediately to reset state. No done pulse.

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
- Defined:
  - Running XOR of every transmitted byte is kept and cleared on start.
  - After the last MEM byte: CHK sends the XOR byte (tx_start pulse), CHK_WAIT waits for tx_done, then FIN.
  - Total bytes = 197 by default.
- Undefined: no checksum register; NEXT goes directly to FIN.

Decomposition:
- Shared package dbg_pkg holds:
  - state enum
  - phase enum (PH_PC, PH_REG, PH_MEM)
  - BYTES_PER_WORD = NBITS/8 constant
  - dump byte-count function
- Sub-module word_serializer: load/shift register, byte counter, last_byte flag. The FSM in dump_sequencer handles only sequencing.

Test Plan:
- Reset: hold rst=0 with start=1 -> all outputs 0, busy=0; release -> still IDLE until a start pulse.
- PC word: current_pc=0x0040_0010, tx_done 3 cycles after each tx_start.
  - tx_byte sequence must be 0x00,0x40,0x00,0x10.
  - tx_start is a single-cycle pulse.
- Full dump: reg[i]=i*0x01010101, mem[w]=0xA5000000+w, DM_WORDS=16.
  - Exactly 196 tx_start pulses in order.
  - dm_addr steps 0,4,...,60.
  - done pulses once; dbg_own drops in the same cycle as busy.
- Busy guard: a second start mid-dump -> ignored, byte count is still 196. tx_done pulses while in SEND are ignored.
- Abort: rst=0 after byte 50 -> busy=0, dbg_own=0 at once, no done. A new start then restarts from PC byte 0.
- With DUMP_CHECKSUM_EN and all data zero except PC=0x0000_00FF -> 197th byte = 0xFF.
